// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, instruction register and a three-state
// IDLE/FETCH/VALID handshake towards a combinational instruction memory.
module instr_fetch_unit #(
    parameter int unsigned byte_W = 4,
    parameter int unsigned Addr_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic                  instr_ack,
    input  logic                  stall,
    input  logic                  pc_load,
    input  logic [Addr_W-1:0]     pc_target,
    output logic [Addr_W-1:0]     mem_address,
    input  logic [8*byte_W-1:0]   mem_instruction,
    output logic [8*byte_W-1:0]   instr,
    output logic                  instr_valid,
    output logic [Addr_W-1:0]     pc_out,
    output logic [Addr_W-1:0]     pc_plus8,
    output logic [15:0]           fetch_count,
    output logic                  align_err
);

    localparam int unsigned InstrW = 8 * byte_W;

    typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

    state_e              state_q, state_d;
    logic [Addr_W-1:0]   pc_q, pc_d;
    logic [Addr_W-1:0]   target_aligned;
    logic [InstrW-1:0]   ir_q, ir_d;
    logic [15:0]         count_q, count_d;
    logic                err_q, err_d;

    // Branch targets are forced onto a word boundary.
    assign target_aligned = {pc_target[Addr_W-1:2], 2'b00};

    // Next-state logic for the FSM, PC, IR, capture counter and alignment flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        err_d   = err_q | (pc_load & (pc_target[1:0] != 2'b00));
        case (state_q)
            StIdle: begin
                if (pc_load) begin
                    pc_d = target_aligned;
                end
                // The FETCH cycle that follows reads from the freshly loaded PC.
                if (fetch_req) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (pc_load) begin
                    // Flush: the in-flight fetch is dropped, IR keeps its old value.
                    pc_d    = target_aligned;
                    state_d = StIdle;
                end else if (!stall) begin
                    ir_d    = mem_instruction;
                    pc_d    = pc_q + Addr_W'(4);
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = StValid;
                end
            end
            StValid: begin
                if (pc_load) begin
                    pc_d = target_aligned;
                end
                if (instr_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign mem_address = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus8    = pc_q + Addr_W'(8);
    assign instr       = ir_q;
    assign instr_valid = (state_q == StValid);
    assign fetch_count = count_q;
    assign align_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural model predicts each
// captured instruction and a monitor checks it when instr_valid rises.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0, instr_ack = 1'b0, stall = 1'b0, pc_load = 1'b0;
    logic [7:0]  pc_target = 8'h00;
    logic [7:0]  mem_address;
    logic [31:0] mem_instruction;
    logic [31:0] instr;
    logic        instr_valid;
    logic [7:0]  pc_out, pc_plus8;
    logic [15:0] fetch_count;
    logic        align_err;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic [7:0]  pc;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q [$];

    // Reference model state: mode 0 = idle, 1 = fetching, 2 = holding result.
    int          m_mode;
    int          m_pc;
    int          m_cnt;
    bit          m_err;
    logic [31:0] m_ir;

    always #5 clk = ~clk;

    assign mem_instruction = {mem[mem_address + 8'd3], mem[mem_address + 8'd2],
                              mem[mem_address + 8'd1], mem[mem_address]};

    instr_fetch_unit #(.byte_W(4), .Addr_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .instr_ack       (instr_ack),
        .stall           (stall),
        .pc_load         (pc_load),
        .pc_target       (pc_target),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .pc_out          (pc_out),
        .pc_plus8        (pc_plus8),
        .fetch_count     (fetch_count),
        .align_err       (align_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {mem[(a + 3) % 256], mem[(a + 2) % 256], mem[(a + 1) % 256], mem[a % 256]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_err = 0; m_ir = '0;
        exp_q.delete();
    endtask

    // Apply the behavioural rules for one rising edge using the driven inputs.
    task automatic model_edge(input bit fr, input bit ack, input bit st, input bit ld,
                              input int tgt);
        int aligned;
        aligned = tgt - (tgt % 4);
        if (ld && (tgt % 4) != 0) m_err = 1;
        if (m_mode == 0) begin
            if (ld) m_pc = aligned;
            if (fr) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ld) begin
                m_pc = aligned;
                m_mode = 0;
            end else if (!st) begin
                m_ir  = word_at(m_pc);
                m_pc  = (m_pc + 4) % 256;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_mode = 2;
                exp_q.push_back('{ins: m_ir, pc: 8'(m_pc), cnt: 16'(m_cnt)});
            end
        end else begin
            if (ld) m_pc = aligned;
            if (ack) m_mode = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check visible state.
    task automatic drive(input bit fr, input bit ack, input bit st, input bit ld,
                         input logic [7:0] tgt);
        fetch_req = fr; instr_ack = ack; stall = st; pc_load = ld; pc_target = tgt;
        @(posedge clk);
        model_edge(fr, ack, st, ld, int'(tgt));
        @(negedge clk);
        chk("pc_out",      32'(pc_out),      32'(m_pc));
        chk("mem_address", 32'(mem_address), 32'(m_pc));
        chk("pc_plus8",    32'(pc_plus8),    32'((m_pc + 8) % 256));
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == 2));
        chk("instr",       instr,            m_ir);
        chk("align_err",   32'(align_err),   32'(m_err));
    endtask

    // Monitor: every new presentation of instr_valid consumes one predicted capture.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(instr_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_instr",  instr,             e.ins);
                    chk("sb_pc",     32'(pc_out),      32'(e.pc));
                    chk("sb_count",  32'(fetch_count), 32'(e.cnt));
                end
            end
            prev_valid <= instr_valid;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'h12; mem[3] = 8'hE4;
        mem[4] = 8'h04; mem[5] = 8'h30; mem[6] = 8'h12; mem[7] = 8'hE4;
        mem[8] = 8'h01; mem[9] = 8'h30; mem[10] = 8'h43; mem[11] = 8'hE0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("reset_pc",    32'(pc_out),      32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr,            32'd0);
        chk("reset_count", 32'(fetch_count), 32'd0);
        chk("reset_err",   32'(align_err),   32'd0);
        reset = 1'b0;

        // First fetch from address 0: valid two edges after the request edge.
        drive(1, 0, 0, 0, 8'h00);
        chk("lat_fetch_not_valid", 32'(instr_valid), 32'd0);
        drive(0, 0, 0, 0, 8'h00);
        chk("first_instr", instr,            32'hE4121000);
        chk("first_pc",    32'(pc_out),      32'd4);
        chk("first_pc8",   32'(pc_plus8),    32'd12);
        chk("first_count", 32'(fetch_count), 32'd1);
        drive(1, 1, 0, 0, 8'h00);

        // Two more fetch/ack rounds.
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 8'h00);
            drive(1, 0, 0, 0, 8'h00);
            if (k == 0) chk("second_instr", instr, 32'hE4123004);
            drive(0, 1, 0, 0, 8'h00);
        end
        chk("third_instr", instr,            32'hE0433001);
        chk("third_pc",    32'(pc_out),      32'd12);
        chk("third_count", 32'(fetch_count), 32'd3);

        // Stall held three cycles in FETCH, capture on the first unstalled cycle.
        drive(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 8'h00);
        chk("stall_pc", 32'(pc_out), 32'd12);
        drive(0, 0, 0, 0, 8'h00);
        chk("stall_capture", instr, word_at(12));
        drive(0, 1, 0, 0, 8'h00);

        // Misaligned branch during FETCH flushes the fetch.
        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 1, 8'h11);
        chk("flush_pc",    32'(pc_out),      32'h10);
        chk("flush_err",   32'(align_err),   32'd1);
        chk("flush_count", 32'(fetch_count), 32'd4);
        chk("flush_instr", instr,            word_at(12));

        // PC wrap from 0xFC to 0.
        drive(0, 0, 0, 1, 8'hFC);
        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        chk("wrap_pc",  32'(pc_out),   32'h00);
        chk("wrap_pc8", 32'(pc_plus8), 32'h08);
        chk("wrap_instr", instr, word_at(252));
        drive(0, 1, 0, 0, 8'h00);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                  8'($urandom_range(0, 255)));
        end

        // Asynchronous reset while an instruction is being held.
        for (int k = 0; k < 20 && m_mode != 2; k++) begin
            drive(1, 0, 0, 0, 8'h00);
        end
        chk("pre_reset_valid", 32'(instr_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", instr,            32'd0);
        chk("async_pc",    32'(pc_out),      32'd0);
        chk("async_count", 32'(fetch_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        chk("post_reset_instr", instr, 32'hE4121000);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
